// File: rtl/booth_mult_datapath.sv
// Radix-2 Booth multiplier datapath for MULT/MULTU.
// Sequenced by the external multiplier controller; captures HI/LO at the end.
module booth_mult_datapath #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 2)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             is_signed,
    input  logic             initialize,
    input  logic             accum_load,
    input  logic             comp,
    input  logic             sh_en,
    output logic [1:0]       status,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             prod_valid
);

    localparam logic [CW-1:0] STEPS = CW'(WIDTH + 1);

    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     mq;
    logic [WIDTH:0]     mcand;
    logic               qm1;
    logic [CW-1:0]      cnt;
    logic               busy;

    logic [WIDTH:0]     ext_a;
    logic [WIDTH:0]     ext_b;
    logic [WIDTH:0]     addend;
    logic [2*WIDTH+1:0] aq;
    logic               finish;

    // One extra sign bit lets MULTU run as a signed (WIDTH+1)-bit multiply
    assign ext_a  = {is_signed & op_a[WIDTH-1], op_a};
    assign ext_b  = {is_signed & op_b[WIDTH-1], op_b};
    assign addend = comp ? (~mcand + (WIDTH+1)'(1)) : mcand;
    assign aq     = {acc, mq};
    assign finish = busy & (cnt == '0) & ~initialize;

    assign done   = (cnt == '0);
    assign status = initialize ? {op_b[0], 1'b0} : {mq[0], qm1};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc        <= '0;
            mq         <= '0;
            mcand      <= '0;
            qm1        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= finish;
            if (finish) begin
                hi   <= aq[2*WIDTH-1:WIDTH];
                lo   <= aq[WIDTH-1:0];
                busy <= 1'b0;
            end
            if (initialize) begin
                mcand <= ext_a;
                mq    <= ext_b;
                acc   <= '0;
                qm1   <= 1'b0;
                cnt   <= STEPS;
                busy  <= 1'b1;
            end else if (accum_load) begin
                acc <= acc + addend;
            end else if (sh_en && (cnt != '0)) begin
                acc <= {acc[WIDTH], acc[WIDTH:1]};
                mq  <= {acc[0], mq[WIDTH:1]};
                qm1 <= mq[0];
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_datapath.sv
// Randomised and directed bench for booth_mult_datapath.
// Bench-side controller drives Booth steps; a monitor scores hi/lo pulses.
module tb_booth_mult_datapath;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        is_signed = 1'b0;
    logic        initialize = 1'b0;
    logic        accum_load = 1'b0;
    logic        comp = 1'b0;
    logic        sh_en = 1'b0;
    logic [1:0]  status;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        prod_valid;

    int tests = 0;
    int fails = 0;
    int n_push = 0;
    int n_pulse = 0;
    logic [63:0] expq[$];

    booth_mult_datapath #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST),
        .op_a(op_a), .op_b(op_b), .is_signed(is_signed),
        .initialize(initialize), .accum_load(accum_load),
        .comp(comp), .sh_en(sh_en),
        .status(status), .done(done),
        .hi(hi), .lo(lo), .prod_valid(prod_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the mathematical product, truncated to 64 bits
    function automatic logic [63:0] ref_prod(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic s);
        int    ia;
        int    ib;
        longint la;
        longint lb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (s) begin
            ia = a;
            ib = b;
            la = ia;
            lb = ib;
            return la * lb;
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    always @(negedge CLK) begin
        if (prod_valid === 1'b1) begin
            n_pulse++;
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_pulse: got %h%h expected none",
                         hi, lo);
            end else begin
                check("product", {hi, lo}, expq.pop_front());
            end
        end
    end

    task automatic do_init(input logic [31:0] a,
                           input logic [31:0] b,
                           input logic s);
        @(negedge CLK);
        op_a = a;
        op_b = b;
        is_signed = s;
        initialize = 1'b1;
        accum_load = 1'b0;
        sh_en = 1'b0;
        comp = 1'b0;
        #1 check("init_status", 64'(status), 64'({b[0], 1'b0}));
        @(negedge CLK);
        initialize = 1'b0;
        #1 check("busy_done", 64'(done), 64'd0);
    endtask

    task automatic booth_step(output bit added);
        logic [1:0] st;
        st = status;
        added = 1'b0;
        if (st == 2'b01 || st == 2'b10) begin
            accum_load = 1'b1;
            comp = (st == 2'b10);
            @(negedge CLK);
            accum_load = 1'b0;
            comp = 1'b0;
            added = 1'b1;
        end
        sh_en = 1'b1;
        @(negedge CLK);
        sh_en = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a,
                          input logic [31:0] b,
                          input logic s,
                          input logic [63:0] exp,
                          input bit pre,
                          output int adds);
        int shifts;
        bit added;
        expq.push_back(exp);
        n_push++;
        do_init(a, b, s);
        if (pre) begin
            accum_load = 1'b1;
            sh_en = 1'b1;
            comp = 1'b0;
            @(negedge CLK);
            accum_load = 1'b0;
            sh_en = 1'b0;
        end
        shifts = 0;
        adds = 0;
        while (!done && shifts < 200) begin
            booth_step(added);
            if (added) adds++;
            shifts++;
            if (shifts < 33 && done) begin
                tests++;
                fails++;
                $display("FAIL early_done: got done at shift %0d", shifts);
            end
        end
        check("shift_count", 64'(shifts), 64'd33);
    endtask

    initial begin
        int adds;
        bit added;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [31:0] h0;
        logic [31:0] l0;
        logic [1:0]  s0;

        #2 RST = 1'b0;
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_valid", 64'(prod_valid), 64'd0);
        check("rst_done", 64'(done), 64'd1);
        check("rst_status", 64'(status), 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        run_op(32'd7, 32'hFFFFFFFD, 1'b1,
               64'hFFFFFFFF_FFFFFFEB, 1'b0, adds);
        run_op(32'hFFFFFFFF, 32'd2, 1'b0,
               64'h00000001_FFFFFFFE, 1'b0, adds);
        run_op(32'hFFFFFFFF, 32'd2, 1'b1,
               64'hFFFFFFFF_FFFFFFFE, 1'b0, adds);
        run_op(32'h80000000, 32'h80000000, 1'b1,
               64'h40000000_00000000, 1'b0, adds);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
               64'hFFFFFFFE_00000001, 1'b0, adds);
        run_op(32'd0, 32'h12345678, 1'b1, 64'd0, 1'b0, adds);
        run_op(32'd9, 32'd1, 1'b0, 64'd9, 1'b0, adds);

        // Extra shifts at cnt == 0 after capture must change nothing
        @(negedge CLK);
        h0 = hi;
        l0 = lo;
        s0 = status;
        for (int i = 0; i < 3; i++) begin
            sh_en = 1'b1;
            @(negedge CLK);
        end
        sh_en = 1'b0;
        check("idle_hi", 64'(hi), 64'(h0));
        check("idle_lo", 64'(lo), 64'(l0));
        check("idle_status", 64'(status), 64'(s0));
        check("idle_done", 64'(done), 64'd1);

        // Abort after 10 shifts, restart with new operands
        do_init(32'h1234_5678, 32'h9ABC_DEF1, 1'b1);
        for (int i = 0; i < 10; i++) booth_step(added);
        run_op(32'd3, 32'd5, 1'b1, 64'd15, 1'b0, adds);
        @(negedge CLK);
        check("abort_lo", 64'(lo), 64'd15);

        // Accumulate wins over shift in the same cycle
        rb = $urandom;
        run_op(32'd5, rb, 1'b1,
               ref_prod(32'd5, rb, 1'b1) + 64'd5, 1'b1, adds);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            run_op(ra, rb, rs, ref_prod(ra, rb, rs), 1'b0, adds);
        end

        // Reset mid-operation clears HI/LO and never pulses
        @(negedge CLK);
        do_init(32'h0000_0011, 32'h0000_0013, 1'b0);
        for (int i = 0; i < 7; i++) booth_step(added);
        RST = 1'b0;
        #1;
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        check("mid_rst_done", 64'(done), 64'd1);
        check("mid_rst_valid", 64'(prod_valid), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sh_en = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        sh_en = 1'b0;

        repeat (3) @(negedge CLK);
        check("pulse_count", 64'(n_pulse), 64'(n_push));
        check("queue_empty", 64'(expq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
